// File: rtl/rv32_types.sv
// Shared RV32 memory-stage types: request bundle, memory op codes, responder FSM states.
// No logic; types and constants only.
// No flow control here; consumers define their own handshakes.
package rv32_types;

  // Upper bound on the responder's completion latency (4-bit countdown)
  localparam int MEM_LATENCY_MAX = 15;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;

  typedef struct packed {
    logic [31:0] addr;
    mem_op_t     op;
    logic [31:0] data;
  } memory_request_t;

  typedef enum logic {
    RESP_IDLE = 1'b0,
    RESP_BUSY = 1'b1
  } mem_resp_state_t;

endpackage

// File: rtl/rv32_mem_align.sv
// Byte-enable/store-lane generation, load extraction/extension and fault detection.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs within the same cycle.
module rv32_mem_align
  import rv32_types::*;
#(
  parameter int MEM_WORDS = 16384
) (
  input  mem_op_t     op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_word,
  output logic [3:0]  byte_en,
  output logic [31:0] write_word,
  output logic [31:0] load_data,
  output logic        access_fault
);

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        is_store;
  logic        misaligned;
  logic        out_of_range;
  logic [1:0]  offset;
  logic [31:0] shifted;

  assign offset = addr[1:0];

  // Decode access size/direction and the fault condition
  always_comb begin
    is_byte  = (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_SB);
    is_half  = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
    is_word  = (op == MEM_LW) || (op == MEM_SW);
    is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    misaligned   = (is_half && offset[0]) || (is_word && (offset != 2'b00));
    out_of_range = ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
    access_fault = (op != MEM_NOP) && (misaligned || out_of_range);
  end

  // Store path: lane enables and data replicated across every candidate lane
  always_comb begin
    byte_en    = 4'b0000;
    write_word = store_data;
    if (is_byte) begin
      write_word = {4{store_data[7:0]}};
    end else if (is_half) begin
      write_word = {2{store_data[15:0]}};
    end
    if (is_store && !access_fault) begin
      if (is_byte) begin
        byte_en = 4'b0001 << offset;
      end else if (is_half) begin
        byte_en = 4'b0011 << offset;
      end else begin
        byte_en = 4'b1111;
      end
    end
  end

  // Load path: shift the addressed lane down, then sign- or zero-extend
  always_comb begin
    shifted   = mem_word >> {offset, 3'b000};
    load_data = 32'h0;
    if (!access_fault) begin
      case (op)
        MEM_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
        MEM_LBU: load_data = {24'h0, shifted[7:0]};
        MEM_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
        MEM_LHU: load_data = {16'h0, shifted[15:0]};
        MEM_LW:  load_data = mem_word;
        default: load_data = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/rv32_data_mem_responder.sv
// Data-memory responder for the RV32 memory stage with a fixed, parameterised completion latency.
// Latency: request_done asserts LATENCY cycles after acceptance, for exactly one cycle.
// Backpressure: the stage stalls while request_done is low; a NOP while busy aborts the request.
module rv32_data_mem_responder
  import rv32_types::*;
#(
  parameter int MEM_WORDS = 16384,
  parameter int LATENCY   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  memory_request_t data_request,
  output logic            request_done,
  output logic [31:0]     read_data,
  output logic            access_fault
);

  localparam int         IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  mem_resp_state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  memory_request_t req_q, req_d;
  logic            commit;

  logic [31:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      mem_word;
  logic [3:0]       byte_en;
  logic [31:0]      write_word;
  logic [31:0]      load_data;
  logic             fault;

  // Word index comes from the latched request only; out-of-range indices are
  // flagged as faults by the align block, so the truncated read is never used.
  assign idx      = req_q.addr[IDX_W+1:2];
  assign mem_word = mem[idx];

  rv32_mem_align #(
    .MEM_WORDS(MEM_WORDS)
  ) u_align (
    .op          (req_q.op),
    .addr        (req_q.addr),
    .store_data  (req_q.data),
    .mem_word    (mem_word),
    .byte_en     (byte_en),
    .write_word  (write_word),
    .load_data   (load_data),
    .access_fault(fault)
  );

  // FSM state, latency countdown and latched request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESP_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '{addr: 32'h0, op: MEM_NOP, data: 32'h0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Next-state logic and outputs; outputs depend on registered state only
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    commit       = 1'b0;
    request_done = 1'b0;
    read_data    = 32'h0;
    access_fault = 1'b0;
    case (state_q)
      RESP_IDLE: begin
        if (data_request.op != MEM_NOP) begin
          req_d   = data_request;
          cnt_d   = CNT_LOAD;
          state_d = RESP_BUSY;
        end
      end
      RESP_BUSY: begin
        if (cnt_q == 4'd0) begin
          request_done = 1'b1;
          read_data    = load_data;
          access_fault = fault;
          commit       = 1'b1;
          state_d      = RESP_IDLE;
          req_d.op     = MEM_NOP;
        end else if (data_request.op == MEM_NOP) begin
          // Pipeline flush: drop the request without writing
          state_d  = RESP_IDLE;
          cnt_d    = 4'd0;
          req_d.op = MEM_NOP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = RESP_IDLE;
      end
    endcase
  end

  // Synchronous lane-masked write at the closing edge of the done cycle; contents survive reset
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (byte_en[lane]) begin
          mem[idx][lane*8 +: 8] <= write_word[lane*8 +: 8];
        end
      end
    end
  end

endmodule
